// File: rtl/cpu_step_pkg.sv
// Shared constants and FSM encoding for the CPU state stepper.
// STATE_W : width of the CPU state vector (cluster i/o width)
// CHUNK_W : load/dump beat width
// NB      : beats per state vector
// LAST_BITS : valid bits carried by the final beat
package cpu_step_pkg;

  localparam int STATE_W   = 1894;
  localparam int CHUNK_W   = 64;
  localparam int NB        = (STATE_W + CHUNK_W - 1) / CHUNK_W;
  localparam int LAST_BITS = STATE_W - (NB - 1) * CHUNK_W;
  localparam int PAD_W     = NB * CHUNK_W - STATE_W;
  localparam int BEAT_W    = $clog2(NB);
  localparam int SET_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DUMP   = 3'd4
  } state_e;

endpackage

// File: rtl/cpu_state_chunker.sv
// Beat-indexed access into the state vector, shared by load and dump.
// Ports:
//   state_i    : current state vector
//   beat_i     : beat index
//   wr_en_i    : write chunk beat_i with wr_data_i
//   wr_data_i  : incoming chunk (bits above LAST_BITS ignored on the last beat)
//   wr_state_o : state vector with the addressed chunk replaced (if wr_en_i)
//   rd_data_o  : addressed chunk, zero-filled above the vector end
module cpu_state_chunker
  import cpu_step_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic [BEAT_W-1:0]  beat_i,
  input  logic               wr_en_i,
  input  logic [CHUNK_W-1:0] wr_data_i,
  output logic [STATE_W-1:0] wr_state_o,
  output logic [CHUNK_W-1:0] rd_data_o
);

  logic [NB*CHUNK_W-1:0] padded;
  logic [CHUNK_W-1:0]    chunks [NB];

  assign padded = {{PAD_W{1'b0}}, state_i};

  for (genvar b = 0; b < NB; b++) begin : g_beat
    localparam int LO = b * CHUNK_W;
    localparam int W  = (b == NB - 1) ? LAST_BITS : CHUNK_W;
    logic sel;
    assign sel = wr_en_i && (beat_i == BEAT_W'(b));
    assign wr_state_o[LO +: W] = sel ? wr_data_i[W-1:0] : state_i[LO +: W];
    assign chunks[b] = padded[LO +: CHUNK_W];
  end

  assign rd_data_o = (beat_i < BEAT_W'(NB)) ? chunks[beat_i] : '0;

endmodule

// File: rtl/cpu_state_stepper.sv
// Holds the CPU state vector, feeds it to the external next-state cluster
// and commits the cluster result after a programmable settle time. Also
// provides chunked load and dump of the vector.
//
// Optional feature macro: CPU_STEP_PERF_EN adds perf_steps[31:0], a
// saturating count of committed steps since reset.
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   load_valid/ready/data : load beats, beat 0 = bits [63:0]
//   step_req, step_cnt    : start a run of step_cnt steps (0 runs one)
//   state_o               : registered state, drives the cluster i bus
//   next_i                : cluster o bits, sampled only in COMMIT
//   dump_req              : start a readback
//   dump_valid/ready/data : dump beats, zero-filled past the vector end
//   busy, done            : not-idle flag, one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting; load > step > dump priority
// LOAD   | accepting NB beats into the state vector
// SETTLE | state_o held stable while the cluster settles
// COMMIT | state_o <= next_i, decrement remaining steps
// DUMP   | presenting NB beats of the state vector
module cpu_state_stepper
  import cpu_step_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [CHUNK_W-1:0] load_data,
  input  logic               step_req,
  input  logic [CNT_W-1:0]   step_cnt,
  output logic [STATE_W-1:0] state_o,
  input  logic [STATE_W-1:0] next_i,
  input  logic               dump_req,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [CHUNK_W-1:0] dump_data,
  output logic               busy,
  output logic               done
`ifdef CPU_STEP_PERF_EN
  ,
  output logic [31:0]        perf_steps
`endif
);

  localparam logic [SET_W-1:0]  SETTLE_INIT = SET_W'(SETTLE - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(NB - 1);

  state_e              state_q, state_d;
  logic [STATE_W-1:0]  vec_q, vec_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                load_ready_q, load_ready_d;
  logic                done_q, done_d;
  logic                load_hs;
  logic                commit;
  logic [STATE_W-1:0]  vec_wr;
  logic [CHUNK_W-1:0]  rd_chunk;

  assign load_hs = (state_q == ST_LOAD) && load_valid && load_ready_q;

  cpu_state_chunker u_chunker (
    .state_i    (vec_q),
    .beat_i     (beat_q),
    .wr_en_i    (load_hs),
    .wr_data_i  (load_data),
    .wr_state_o (vec_wr),
    .rd_data_o  (rd_chunk)
  );

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    beat_d       = beat_q;
    settle_d     = settle_q;
    rem_d        = rem_q;
    load_ready_d = load_ready_q;
    done_d       = 1'b0;
    commit       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d      = ST_LOAD;
          load_ready_d = 1'b1;
          beat_d       = '0;
        end else if (step_req) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_INIT;
          rem_d    = (step_cnt == '0) ? CNT_W'(1) : step_cnt;
        end else if (dump_req) begin
          state_d = ST_DUMP;
          beat_d  = '0;
        end
      end
      ST_LOAD: begin
        if (load_hs) begin
          vec_d = vec_wr;
          if (beat_q == LAST_BEAT) begin
            state_d      = ST_IDLE;
            load_ready_d = 1'b0;
            done_d       = 1'b1;
            beat_d       = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_COMMIT;
        else                settle_d = settle_q - SET_W'(1);
      end
      ST_COMMIT: begin
        vec_d  = next_i;
        commit = 1'b1;
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_INIT;
        end
      end
      ST_DUMP: begin
        if (dump_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      beat_q       <= '0;
      settle_q     <= '0;
      rem_q        <= '0;
      load_ready_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      beat_q       <= beat_d;
      settle_q     <= settle_d;
      rem_q        <= rem_d;
      load_ready_q <= load_ready_d;
      done_q       <= done_d;
    end
  end

  assign state_o    = vec_q;
  assign load_ready = load_ready_q;
  assign busy       = (state_q != ST_IDLE);
  assign dump_valid = (state_q == ST_DUMP);
  assign dump_data  = dump_valid ? rd_chunk : '0;
  // A run's done is flagged during its final COMMIT cycle; load/dump done
  // follows the last handshake by one cycle.
  assign done       = done_q || ((state_q == ST_COMMIT) && (rem_q == CNT_W'(1)));

`ifdef CPU_STEP_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        perf_q <= '0;
    else if (commit && perf_q != '1)   perf_q <= perf_q + 32'd1;
  end
  assign perf_steps = perf_q;
`endif

endmodule

// File: tb/tb_cpu_state_stepper.sv
module tb_cpu_state_stepper;
  import cpu_step_pkg::*;

  localparam int SETTLE_TB = 2;
  localparam int CNT_W_TB  = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load_valid;
  logic               load_ready;
  logic [CHUNK_W-1:0] load_data;
  logic               step_req;
  logic [CNT_W_TB-1:0] step_cnt;
  logic [STATE_W-1:0] state_o;
  logic [STATE_W-1:0] next_i;
  logic               dump_req;
  logic               dump_valid;
  logic               dump_ready;
  logic [CHUNK_W-1:0] dump_data;
  logic               busy;
  logic               done;
`ifdef CPU_STEP_PERF_EN
  logic [31:0]        perf_steps;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [STATE_W-1:0] model;
  int unsigned perf_exp;

  logic [STATE_W-1:0] exp_state_q[$];
  int                 exp_lat_q[$];
  logic [CHUNK_W-1:0] exp_beat_q[$];

  cpu_state_stepper #(.SETTLE(SETTLE_TB), .CNT_W(CNT_W_TB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .step_req   (step_req),
    .step_cnt   (step_cnt),
    .state_o    (state_o),
    .next_i     (next_i),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .busy       (busy),
    .done       (done)
`ifdef CPU_STEP_PERF_EN
    ,
    .perf_steps (perf_steps)
`endif
  );

  always #5 clk = ~clk;

  // Loopback cluster: increment the low 64 bits, pass the rest through.
  assign next_i = {state_o[STATE_W-1:64], state_o[63:0] + 64'd1};

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  function automatic int diff_beat(input logic [STATE_W-1:0] a, input logic [STATE_W-1:0] b);
    logic [NB*CHUNK_W-1:0] pa, pb;
    pa = '0; pb = '0;
    pa[STATE_W-1:0] = a;
    pb[STATE_W-1:0] = b;
    for (int i = 0; i < NB; i++)
      if (pa[i*CHUNK_W +: CHUNK_W] !== pb[i*CHUNK_W +: CHUNK_W]) return i;
    return -1;
  endfunction

  function automatic logic [CHUNK_W-1:0] pat_chunk(input int k);
    return {32'hA5A5_0000 + 32'(k), 32'h0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load_valid = 0; step_req = 0; dump_req = 0; dump_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model = '0;
    perf_exp = 0;
  endtask

  task automatic load_vec(input logic [NB*CHUNK_W-1:0] pv, input bit gaps,
                          input bit with_step, input string name);
    int k = 0;
    int cyc = 0;
    int d0 = done_cnt;
    bit hs;
    int db;
    logic [STATE_W-1:0] exp;
    exp_state_q.push_back(pv[STATE_W-1:0]);
    while (k < NB && cyc < 400) begin
      @(negedge clk);
      load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_data  = pv[k*CHUNK_W +: CHUNK_W];
      step_req   = with_step && (cyc == 0);
      step_cnt   = 16'd2;
      hs = load_valid && load_ready;
      @(posedge clk);
      if (hs) k++;
      cyc++;
    end
    @(negedge clk);
    load_valid = 1'b0;
    step_req   = 1'b0;
    checks++;
    if (k != NB) begin
      errors++; $display("FAIL %s_beats: got %0d handshakes exp %0d", name, k, NB);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s_done: done=%b exp 1 one cycle after last beat", name, done);
    end
    @(posedge clk); #1;
    exp = exp_state_q.pop_front();
    checks++;
    db = diff_beat(state_o, exp);
    if (db >= 0) begin
      errors++; $display("FAIL %s_state: first differing beat %0d", name, db);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL %s_done_count: got %0d exp 1", name, done_cnt - d0);
    end
    model = exp;
  endtask

  task automatic run_steps(input int n, input string name);
    int eff = (n == 0) ? 1 : n;
    int cyc = 0;
    int d0 = done_cnt;
    int lat;
    exp_lat_q.push_back(eff * (SETTLE_TB + 1));
    @(negedge clk);
    step_cnt = CNT_W_TB'(n);
    step_req = 1'b1;
    do begin
      @(negedge clk);
      step_req = 1'b0;
      cyc++;
    end while (done !== 1'b1 && cyc < 300);
    lat = exp_lat_q.pop_front();
    checks++;
    if (cyc != lat) begin
      errors++; $display("FAIL %s_latency: got %0d cycles exp %0d", name, cyc, lat);
    end
    model[63:0] = model[63:0] + 64'(eff);
    perf_exp += eff;
    @(posedge clk); #1;
    checks++;
    if (state_o !== model) begin
      errors++; $display("FAIL %s_state: low64 got %h exp %h", name, state_o[63:0], model[63:0]);
    end
    checks++;
    if (busy !== 1'b0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL %s_end: busy=%b done pulses=%0d exp busy 0 pulses 1", name, busy, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_valid = 0; load_data = '0; step_req = 0; step_cnt = '0;
    dump_req = 0; dump_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (state_o !== '0)     begin errors++; $display("FAIL rst_state: low64 %h exp 0", state_o[63:0]); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_load_ready: %b exp 0", load_ready); end
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL rst_dump_valid: %b exp 0", dump_valid); end
    checks++; if (dump_data !== '0)    begin errors++; $display("FAIL rst_dump_data: %h exp 0", dump_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: %b exp 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: %b exp 0", done); end
    rst_n = 1'b1;
    model = '0;
    perf_exp = 0;
  endtask

  task automatic test_load();
    logic [NB*CHUNK_W-1:0] pv;
    logic [CHUNK_W-1:0] c29;
    for (int k = 0; k < NB; k++) pv[k*CHUNK_W +: CHUNK_W] = pat_chunk(k);
    c29 = pat_chunk(NB - 1);
    load_vec(pv, 1'b0, 1'b0, "load_b2b");
    checks++;
    if (state_o[63:0] !== 64'hA5A5_0000_0000_0000) begin
      errors++; $display("FAIL load_beat0: got %h exp a5a5000000000000", state_o[63:0]);
    end
    checks++;
    if (state_o[STATE_W-1:STATE_W-LAST_BITS] !== c29[LAST_BITS-1:0]) begin
      errors++; $display("FAIL load_last: got %h exp %h", state_o[STATE_W-1:STATE_W-LAST_BITS], c29[LAST_BITS-1:0]);
    end
  endtask

  task automatic test_load_gaps();
    logic [NB*CHUNK_W-1:0] pv;
    for (int k = 0; k < NB; k++) pv[k*CHUNK_W +: CHUNK_W] = {$urandom, $urandom};
    load_vec(pv, 1'b1, 1'b0, "load_gaps");
  endtask

  task automatic test_dump(input string name);
    logic [NB*CHUNK_W-1:0] pv;
    logic [CHUNK_W-1:0] held, exp;
    bit stalled = 0;
    int cyc = 0;
    int k = 0;
    int d0 = done_cnt;
    pv = '0;
    pv[STATE_W-1:0] = model;
    @(negedge clk);
    dump_req = 1'b1;
    dump_ready = 1'b0;
    for (int i = 0; i < NB; i++) exp_beat_q.push_back(pv[i*CHUNK_W +: CHUNK_W]);
    @(negedge clk);
    dump_req = 1'b0;
    while (exp_beat_q.size() > 0 && cyc < 400) begin
      dump_ready = ~dump_ready;
      if (dump_valid === 1'b1) begin
        if (stalled) begin
          checks++;
          if (dump_data !== held) begin
            errors++; $display("FAIL %s_stall: beat %0d got %h exp %h", name, k, dump_data, held);
          end
        end
        if (dump_ready) begin
          exp = exp_beat_q.pop_front();
          checks++;
          if (dump_data !== exp) begin
            errors++; $display("FAIL %s_beat: beat %0d got %h exp %h", name, k, dump_data, exp);
          end
          if (k == NB - 1) begin
            checks++;
            if (dump_data[CHUNK_W-1:LAST_BITS] !== '0) begin
              errors++; $display("FAIL %s_zero_fill: got %h exp 0", name, dump_data[CHUNK_W-1:LAST_BITS]);
            end
          end
          stalled = 0;
          k++;
        end else begin
          held = dump_data;
          stalled = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    dump_ready = 1'b0;
    checks++;
    if (exp_beat_q.size() != 0) begin
      errors++; $display("FAIL %s_timeout: %0d beats outstanding exp 0", name, exp_beat_q.size());
      exp_beat_q.delete();
    end
    checks++;
    if (done !== 1'b1 || dump_valid !== 1'b0 || dump_data !== '0) begin
      errors++; $display("FAIL %s_end: done=%b dump_valid=%b dump_data=%h exp 1 0 0", name, done, dump_valid, dump_data);
    end
    @(posedge clk); #1;
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL %s_done_count: got %0d exp 1", name, done_cnt - d0);
    end
  endtask

  task automatic test_step();
    do_reset();
    run_steps(3, "step3");
    checks++;
    if (state_o[63:0] !== 64'd3) begin
      errors++; $display("FAIL step3_value: got %0d exp 3", state_o[63:0]);
    end
    run_steps(0, "step0");
    checks++;
    if (state_o[63:0] !== 64'd4) begin
      errors++; $display("FAIL step0_value: got %0d exp 4", state_o[63:0]);
    end
  endtask

  task automatic test_priority();
    logic [NB*CHUNK_W-1:0] pv;
    for (int k = 0; k < NB; k++) pv[k*CHUNK_W +: CHUNK_W] = {32'(k), 32'h1234_5678};
    load_vec(pv, 1'b0, 1'b1, "prio_load");
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (state_o[63:0] !== 64'h0000_0000_1234_5678 || busy !== 1'b0) begin
      errors++; $display("FAIL prio_step_dropped: low64 %h busy %b exp 0000000012345678 0", state_o[63:0], busy);
    end
  endtask

  task automatic test_back_to_back();
    run_steps(2, "b2b_step");
    test_dump("b2b_dump");
    run_steps(1, "b2b_step1");
  endtask

  task automatic test_abort();
    int d0;
    @(negedge clk);
    step_cnt = 16'd5;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (state_o !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_reset: low64 %h busy %b done %b exp 0 0 0", state_o[63:0], busy, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model = '0;
    perf_exp = 0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || state_o !== '0) begin
      errors++; $display("FAIL abort_no_done: pulses %0d low64 %h exp 0 0", done_cnt - d0, state_o[63:0]);
    end
  endtask

  task automatic test_perf();
    do_reset();
    run_steps(3, "perf3");
    run_steps(4, "perf4");
    checks++;
    if (state_o[63:0] !== 64'd7) begin
      errors++; $display("FAIL perf_state: got %0d exp 7", state_o[63:0]);
    end
`ifdef CPU_STEP_PERF_EN
    checks++;
    if (perf_steps !== 32'(perf_exp)) begin
      errors++; $display("FAIL perf_steps: got %0d exp %0d", perf_steps, perf_exp);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_dump("dump_pat");
    test_load_gaps();
    test_dump("dump_rand");
    test_step();
    test_priority();
    test_back_to_back();
    test_abort();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
